// File: rtl/flowcontrol_seq.sv
// flowcontrol_seq: N_CH debounced valve channels with min open/closed hold
// times. Optional watchdog (macro FLOWCTRL_WDOG_EN) force-closes and faults.
//
// Ports:
//   clk, rst_n  - rising-edge clock, async active-low reset
//   en          - global enable, 0 closes every channel
//   sens        - 4 sensor bits per channel, {A,B,C,D} with A as MSB
//   fault_clr   - clears all watchdog fault bits
//   valve       - registered valve commands
//   demand      - raw valve equation from the registered sensors
//   fault       - sticky watchdog faults (0 without FLOWCTRL_WDOG_EN)
//   any_open    - OR of valve
module flowcontrol_seq #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8,
  parameter int DEB_CYC = 4,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 8,
  parameter int MAX_ON  = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [4*N_CH-1:0] sens,
  input  logic              fault_clr,
  output logic [N_CH-1:0]   valve,
  output logic [N_CH-1:0]   demand,
  output logic [N_CH-1:0]   fault,
  output logic              any_open
);

`ifdef FLOWCTRL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  localparam logic [CNT_W-1:0] T_SAT    = '1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_ON_C = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OF_C = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] WD_LIM   = CNT_W'(MAX_ON - 1);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    ARM_ON  = 2'd1,
    OPEN    = 2'd2,
    ARM_OFF = 2'd3
  } st_e;

  logic [4*N_CH-1:0] s_q;
  st_e               st_q  [N_CH];
  st_e               st_d  [N_CH];
  logic [CNT_W-1:0]  t_q   [N_CH];
  logic [CNT_W-1:0]  t_d   [N_CH];
  logic [CNT_W-1:0]  dc_q  [N_CH];
  logic [CNT_W-1:0]  dc_d  [N_CH];
  logic [N_CH-1:0]   valve_q;
  logic [N_CH-1:0]   valve_d;
  logic [N_CH-1:0]   fault_q;
  logic [N_CH-1:0]   fault_d;
  logic [N_CH-1:0]   wdog;

  always_comb begin
    demand = '0;
    for (int i = 0; i < N_CH; i++) begin
      demand[i] = (~s_q[4*i+3] & ~s_q[4*i+2])
                | (~s_q[4*i+3] & ~s_q[4*i+1])
                | ( s_q[4*i+2] & ~s_q[4*i+1] & s_q[4*i])
                | ( s_q[4*i+3] &  s_q[4*i+2] & s_q[4*i+1]);
    end
  end

  always_comb begin
    wdog    = '0;
    valve_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i] = st_q[i];
      dc_d[i] = dc_q[i];
      t_d[i]  = (t_q[i] == T_SAT) ? T_SAT : t_q[i] + CNT_W'(1);
      wdog[i] = WDOG && t_q[i] == WD_LIM
             && (st_q[i] == OPEN || st_q[i] == ARM_OFF);
      if (!en || wdog[i]) begin
        st_d[i] = CLOSED;
        t_d[i]  = '0;
      end else begin
        unique case (st_q[i])
          CLOSED: begin
            if (demand[i] && !fault_q[i] && t_q[i] >= MIN_OF_C) begin
              st_d[i] = ARM_ON;
              dc_d[i] = CNT_W'(1);
            end
          end
          ARM_ON: begin
            // abandoning the arm keeps the timer running
            if (!demand[i]) begin
              st_d[i] = CLOSED;
            end else if (dc_q[i] == DEB_LAST) begin
              st_d[i] = OPEN;
              t_d[i]  = '0;
            end else begin
              dc_d[i] = dc_q[i] + CNT_W'(1);
            end
          end
          OPEN: begin
            if (!demand[i] && t_q[i] >= MIN_ON_C) begin
              st_d[i] = ARM_OFF;
              dc_d[i] = CNT_W'(1);
            end
          end
          ARM_OFF: begin
            if (demand[i]) begin
              st_d[i] = OPEN;
            end else if (dc_q[i] == DEB_LAST) begin
              st_d[i] = CLOSED;
              t_d[i]  = '0;
            end else begin
              dc_d[i] = dc_q[i] + CNT_W'(1);
            end
          end
        endcase
      end
      valve_d[i] = (st_d[i] == OPEN) || (st_d[i] == ARM_OFF);
    end
    // a new fault on the same edge as a clear wins
    fault_d = (fault_q & {N_CH{~fault_clr}}) | wdog;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      valve_q <= '0;
      fault_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= CLOSED;
        t_q[i]  <= T_SAT;
        dc_q[i] <= '0;
      end
    end else begin
      s_q     <= sens;
      valve_q <= valve_d;
      fault_q <= fault_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i] <= st_d[i];
        t_q[i]  <= t_d[i];
        dc_q[i] <= dc_d[i];
      end
    end
  end

  assign valve    = valve_q;
  assign fault    = WDOG ? fault_q : '0;
  assign any_open = |valve_q;

endmodule
